// File: rtl/handshake_arbiter.sv
// Round-robin arbiter that forwards one requester payload at a time over a four-phase
// req/ack handshake to a foreign clock domain. Optional watchdog: define HS_TIMEOUT_EN.
module handshake_arbiter #(
    parameter int N           = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic          xreq,
    output logic [DW-1:0] xdata,
    input  logic          xack,
    output logic          err
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE, DONE} state_t;

    state_t                 state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          sel;
    logic [PW-1:0]          win;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [DW-1:0]          pay [N];

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          abort;
    logic          tmo;
    assign tmo = (cnt == CW'(TIMEOUT - 1));
`endif

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        return N'(1) << idx;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_pay
        assign pay[g] = data[g*DW +: DW];
    end

    // Winner search starts at ptr and wraps, so the last granted requester goes to the back.
    always_comb begin
        logic [PW:0] s;
        logic        found;
        win   = '0;
        found = 1'b0;
        s     = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
            if (!found && req[s[PW-1:0]]) begin
                found = 1'b1;
                win   = s[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], xack};
    end
    assign ack_s = sync_q[SYNC_STAGES-1];

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            xreq  <= 1'b0;
            xdata <= '0;
            grant <= '0;
`ifdef HS_TIMEOUT_EN
            cnt   <= '0;
            abort <= 1'b0;
            err   <= 1'b0;
`endif
        end else begin
            grant <= '0;
`ifdef HS_TIMEOUT_EN
            cnt <= (state == REQ || state == RELEASE) ? cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= win;
                        xdata <= pay[win];
                        xreq  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        xreq  <= 1'b0;
                        state <= RELEASE;
`ifdef HS_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (tmo) begin
                        xreq  <= 1'b0;
                        err   <= 1'b1;
                        abort <= 1'b1;
                        state <= RELEASE;
                        cnt   <= '0;
`endif
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
`ifdef HS_TIMEOUT_EN
                        cnt <= '0;
                        if (abort) begin
                            abort <= 1'b0;
                            ptr   <= next_idx(sel);
                            state <= IDLE;
                        end else begin
                            grant <= onehot(sel);
                            state <= DONE;
                        end
                    end else if (tmo) begin
                        err   <= 1'b1;
                        abort <= 1'b0;
                        ptr   <= next_idx(sel);
                        state <= IDLE;
                        cnt   <= '0;
`else
                        grant <= onehot(sel);
                        state <= DONE;
`endif
                    end
                end
                DONE: begin
                    ptr   <= next_idx(sel);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef HS_TIMEOUT_EN
    // Without the watchdog there is no error source; TIMEOUT is referenced only to keep it bound.
    assign err = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters (2..8).
REQ-002 Parameter DW, default 8: payload width per requester.
REQ-003 Parameter SYNC_STAGES, default 2: flop depth of the xack synchronizer (min 2).
REQ-004 Parameter TIMEOUT, default 255: cycle limit per handshake phase (used only under HS_TIMEOUT_EN).
REQ-005 clk  in  1  sole clock; all flops rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  N  per-requester request level; held high until the matching grant bit pulses.
REQ-008 data  in  N*DW  payloads; requester i at bits [i*DW +: DW]; stable while req[i]=1.
REQ-009 grant  out  N  one-cycle completion pulse, one-hot or zero.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 xreq  out  1  four-phase request to the foreign domain; driven directly from a flop.
REQ-012 xdata  out  DW  registered payload; stable from the xreq rise until the xreq fall.
REQ-013 xack  in  1  asynchronous four-phase acknowledge from the foreign domain.
REQ-014 err  out  1  sticky timeout flag.

Function
REQ-015 xack passes through a SYNC_STAGES-flop synchronizer to give ack_s; no other logic reads xack.
REQ-016 State machine: IDLE, REQ, RELEASE, DONE.
REQ-017 IDLE with any req bit high: winner = first set bit at or above ptr, wrapping modulo N; register sel and xdata = data[sel]; next state REQ.
REQ-018 IDLE with req == 0: remain in IDLE; xdata holds its last value.
REQ-019 REQ: xreq=1; on ack_s=1 go to RELEASE.
REQ-020 RELEASE: xreq=0; on ack_s=0 go to DONE.
REQ-021 DONE: grant[sel]=1 for exactly this cycle; ptr = (sel+1) mod N; next state IDLE.
REQ-022 The first xreq-high cycle is the cycle after the IDLE sample.
REQ-023 Minimum transfer, with xack echoing xreq combinationally: 2*SYNC_STAGES+3 cycles from IDLE sample to the grant pulse.
REQ-024 req[sel] falling mid-transfer has no effect; the transfer completes and grant still pulses.
REQ-025 A req rising during a transfer waits for the next IDLE sample; no request is lost while it is held.
REQ-026 Fairness: while all N requests are held, grants rotate strictly 0,1,..,N-1,0.
REQ-027 ack_s=1 seen in IDLE or DONE is ignored.

Reset
REQ-028 Reset, applied at any time including mid-handshake, gives: state=IDLE, ptr=0, sel=0, xreq=0, xdata=0, grant=0, busy=0, err=0, synchronizer flops=0, timeout counter=0.
REQ-029 The first request after reset may start on the cycle after reset deasserts.

Configuration
REQ-030 With HS_TIMEOUT_EN defined: a counter clears on every state change and increments each cycle spent in REQ or RELEASE.
REQ-031 With HS_TIMEOUT_EN defined, the counter reaching TIMEOUT in REQ: set err, set the abort flag, go to RELEASE.
REQ-032 With HS_TIMEOUT_EN defined, the counter reaching TIMEOUT in RELEASE: set err, go to IDLE with no grant, ptr = sel+1.
REQ-033 With HS_TIMEOUT_EN defined, an aborted transfer leaving RELEASE normally: go to IDLE with no grant, ptr = sel+1, clear the abort flag.
REQ-034 With HS_TIMEOUT_EN defined: err stays set until reset.
REQ-035 Without HS_TIMEOUT_EN: no counter logic; err tied to 0; the design waits on xack indefinitely.

Verification
REQ-036 N=4, SYNC_STAGES=2, single req[2] with data 0xA5, xack = xreq delayed 0 cycles -> xdata=0xA5 while xreq=1; grant=4'b0100 on cycle 7; busy low on cycle 8.
REQ-037 req=4'b1111 held, xack echo -> grant sequence 0001,0010,0100,1000,0001; payloads match the granted requesters.
REQ-038 req[1] transfer, reset asserted for 1 cycle while in REQ -> next cycle xreq=0, busy=0, ptr=0; a following req=4'b0011 grants bit 0 first.
REQ-039 req[3] dropped during RELEASE -> grant=4'b1000 still pulses once; the next IDLE does not reselect 3.
REQ-040 HS_TIMEOUT_EN defined, TIMEOUT=10, xack tied 0 -> xreq falls after 10 REQ cycles; err=1; no grant pulse; err remains 1 until reset.
REQ-041 HS_TIMEOUT_EN undefined, xack tied 0 for 1000 cycles -> xreq stays 1; err=0; then xack=1 -> the handshake completes normally.
